ibram_read_controller: RTL and testbench

Read-side controller for the ping-pong input BRAM banks. It accepts a filled buffer half from the bank selector through a valid/ready handshake and reads every bank in parallel on port B. Each bank is read for its own fill length. The controller presents one lane-per-bank beat per cycle to the downstream compute stream under valid/ready backpressure, then releases the drained half back to the write side.

---
 rtl/ibram_read_controller_if.sv | 46 ++++
 rtl/ibram_read_controller.sv | 177 +++++++++++++++++
 tb/tb_ibram_read_controller.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibram_read_controller_if.sv
// Bundle of the bank-selector handshake, the BRAM port-B bus and the output
// stream used by ibram_read_controller. The master modport is the controller's
// view. The slave modport is the view of the surrounding banks and consumers.
interface ibram_read_controller_if #(
  parameter int NUM_BANKS   = 16,
  parameter int WRITE_WIDTH = 128,
  parameter int WRITE_DEPTH = 128,
  parameter int READ_WIDTH  = 8,
  parameter int READ_DEPTH  = WRITE_WIDTH * WRITE_DEPTH / READ_WIDTH
);
  localparam int AW = $clog2(READ_DEPTH);
  localparam int CW = $clog2(WRITE_DEPTH) + 1;

  // Half handoff from the bank selector.
  logic                                 buf_valid;
  logic                                 buf_ready;
  logic                                 buf_sel;
  logic [NUM_BANKS-1:0][CW-1:0]         buf_words;
  logic                                 buf_release;
  logic                                 buf_release_sel;

  // Port B of every bank, driven in parallel.
  logic [NUM_BANKS-1:0]                 enaB;
  logic [NUM_BANKS-1:0]                 weB;
  logic [NUM_BANKS-1:0][AW:0]           addrB;
  logic [NUM_BANKS-1:0][READ_WIDTH-1:0] doB;

  // One lane-per-bank beat per transfer towards the compute stream.
  logic [NUM_BANKS*READ_WIDTH-1:0]      out_data;
  logic [NUM_BANKS-1:0]                 out_mask;
  logic                                 out_valid;
  logic                                 out_ready;
  logic                                 out_last;

  modport master (
    input  buf_valid, buf_sel, buf_words, doB, out_ready,
    output buf_ready, buf_release, buf_release_sel,
           enaB, weB, addrB, out_data, out_mask, out_valid, out_last
  );

  modport slave (
    output buf_valid, buf_sel, buf_words, doB, out_ready,
    input  buf_ready, buf_release, buf_release_sel,
           enaB, weB, addrB, out_data, out_mask, out_valid, out_last
  );
endinterface

// File: rtl/ibram_read_controller.sv
// Read-side controller for the ping-pong input BRAM banks. It takes a filled half
// and reads all banks in lockstep on port B, each bank for its own length. The
// results go out as one beat per cycle through a 2-entry skid FIFO. When the
// final beat has been consumed, the half is handed back to the write side.
module ibram_read_controller #(
  parameter int NUM_BANKS   = 16,
  parameter int WRITE_WIDTH = 128,
  parameter int WRITE_DEPTH = 128,
  parameter int READ_WIDTH  = 8,
  parameter int READ_DEPTH  = WRITE_WIDTH * WRITE_DEPTH / READ_WIDTH
) (
  input logic                     clk,
  input logic                     rst_n,
  ibram_read_controller_if.master bus
);
  localparam int RATIO = WRITE_WIDTH / READ_WIDTH;
  localparam int AW    = $clog2(READ_DEPTH);
  localparam int CW    = $clog2(WRITE_DEPTH) + 1;
  localparam int LW    = AW + 1;                // lengths reach READ_DEPTH itself
  localparam int DW    = NUM_BANKS * READ_WIDTH;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, RELEASE} state_e;

  typedef struct packed {
    logic [DW-1:0]        data;
    logic [NUM_BANKS-1:0] mask;
    logic                 last;
  } beat_t;

  state_e                       state_q, state_d;
  logic                         sel_q, sel_d;
  logic [NUM_BANKS-1:0][LW-1:0] len_q, len_d, new_len;
  logic [LW-1:0]                max_len_q, max_len_d, new_max;
  logic [LW-1:0]                rd_idx_q, rd_idx_d;
  logic [LW-1:0]                addr_q;

  // A read issued last cycle, whose data is on doB this cycle.
  logic                         pend_q;
  logic [NUM_BANKS-1:0]         pend_mask_q;
  logic                         pend_last_q;

  // Skid FIFO holding up to two beats.
  beat_t                        fifo_q [2];
  logic                         wr_ptr_q, rd_ptr_q;
  logic [1:0]                   count_q;

  logic                         pop, push, issue, last_issue;
  logic [2:0]                   occ_after_pop;
  logic [NUM_BANKS-1:0]         bank_en;
  logic [LW-1:0]                issue_addr;
  logic [CW-1:0]                clamped;
  beat_t                        head, push_beat;

  // Clamp each bank's word count, convert it to an element length and find the longest.
  // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
  always_comb begin
    new_len = '0;
    new_max = '0;
    clamped = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      clamped    = (bus.buf_words[i] > CW'(WRITE_DEPTH)) ? CW'(WRITE_DEPTH) : bus.buf_words[i];
      new_len[i] = LW'(clamped) * LW'(RATIO);
      if (new_len[i] > new_max) new_max = new_len[i];
    end
  end

  // A read may go out only if FIFO plus in-flight, after this cycle's pop, stays within two.
  assign pop           = (count_q != 2'd0) && bus.out_ready;
  assign push          = pend_q;
  assign occ_after_pop = 3'(count_q) + 3'(pend_q) - 3'(pop);
  assign issue         = (state_q == READ) && (occ_after_pop < 3'd2);
  assign last_issue    = (rd_idx_q == max_len_q - LW'(1));
  assign issue_addr    = {sel_q, rd_idx_q[AW-1:0]};
  assign head          = fifo_q[rd_ptr_q];

  // A bank takes part in the current element only while it still has data.
  always_comb begin
    bank_en = '0;
    for (int i = 0; i < NUM_BANKS; i++) bank_en[i] = (rd_idx_q < len_q[i]);
  end

  // Next-state logic: accept a half, issue reads, wait for the final pop, release.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    len_d     = len_q;
    max_len_d = max_len_q;
    rd_idx_d  = rd_idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.buf_valid) begin
          sel_d     = bus.buf_sel;
          len_d     = new_len;
          max_len_d = new_max;
          rd_idx_d  = '0;
          state_d   = (new_max == '0) ? RELEASE : READ;
        end
      end
      READ: begin
        if (issue) begin
          rd_idx_d = rd_idx_q + LW'(1);
          if (last_issue) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!pend_q && pop && head.last) state_d = RELEASE;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Port-B drive and handshake outputs. The address holds its last issued value between reads.
  always_comb begin
    bus.buf_ready       = (state_q == IDLE);
    bus.buf_release     = (state_q == RELEASE);
    bus.buf_release_sel = (state_q == RELEASE) && sel_q;
    bus.enaB            = issue ? bank_en : '0;
    bus.weB             = '0;
    for (int i = 0; i < NUM_BANKS; i++) bus.addrB[i] = issue ? issue_addr : addr_q;
  end

  // Zero the lanes of banks that were not read, so stale doB never leaks out.
  always_comb begin
    push_beat      = '0;
    push_beat.mask = pend_mask_q;
    push_beat.last = pend_last_q;
    for (int i = 0; i < NUM_BANKS; i++)
      push_beat.data[i*READ_WIDTH +: READ_WIDTH] = pend_mask_q[i] ? bus.doB[i] : '0;
  end

  // The stream shows the FIFO head. When the FIFO is empty it shows zeros.
  always_comb begin
    bus.out_valid = (count_q != 2'd0);
    bus.out_data  = bus.out_valid ? head.data : '0;
    bus.out_mask  = bus.out_valid ? head.mask : '0;
    bus.out_last  = bus.out_valid && head.last;
  end

  // Control state, read pipeline and FIFO pointers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      len_q       <= '0;
      max_len_q   <= '0;
      rd_idx_q    <= '0;
      addr_q      <= '0;
      pend_q      <= 1'b0;
      pend_mask_q <= '0;
      pend_last_q <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      len_q       <= len_d;
      max_len_q   <= max_len_d;
      rd_idx_q    <= rd_idx_d;
      if (issue) addr_q <= issue_addr;
      pend_q      <= issue;
      pend_mask_q <= issue ? bank_en : '0;
      pend_last_q <= issue && last_issue;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q     <= count_q + 2'(push) - 2'(pop);
    end
  end

  // FIFO storage. Entries are written as beats arrive.
  // NOTE: storage is deliberately not reset; count_q gates every output, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= push_beat;
  end
endmodule

// File: tb/tb_ibram_read_controller.sv
// Bench for ibram_read_controller. A behavioural BRAM supplies a data pattern
// derived from the address. Each half is expanded into the list of beats it
// should produce. A monitor compares issues and pops against that list.
module tb_ibram_read_controller;
  localparam int NUM_BANKS   = 16;
  localparam int WRITE_WIDTH = 128;
  localparam int WRITE_DEPTH = 128;
  localparam int READ_WIDTH  = 8;
  localparam int READ_DEPTH  = WRITE_WIDTH * WRITE_DEPTH / READ_WIDTH;
  localparam int RATIO       = WRITE_WIDTH / READ_WIDTH;
  localparam int AW          = $clog2(READ_DEPTH);
  localparam int CW          = $clog2(WRITE_DEPTH) + 1;
  localparam int DW          = NUM_BANKS * READ_WIDTH;

  typedef logic [NUM_BANKS-1:0][CW-1:0] words_t;

  typedef struct {
    words_t words;
    logic   sel;
    bit     rand_ready;
    int     exp_beats;
  } vec_t;

  typedef struct {
    logic [DW-1:0]        data;
    logic [NUM_BANKS-1:0] mask;
    logic                 last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ibram_read_controller_if #(
    .NUM_BANKS(NUM_BANKS), .WRITE_WIDTH(WRITE_WIDTH), .WRITE_DEPTH(WRITE_DEPTH),
    .READ_WIDTH(READ_WIDTH), .READ_DEPTH(READ_DEPTH)
  ) bus ();

  ibram_read_controller #(
    .NUM_BANKS(NUM_BANKS), .WRITE_WIDTH(WRITE_WIDTH), .WRITE_DEPTH(WRITE_DEPTH),
    .READ_WIDTH(READ_WIDTH), .READ_DEPTH(READ_DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Expected half: per-bank lengths and the beat list still to be popped.
  int    m_len [NUM_BANKS];
  int    m_max;
  logic  m_sel;
  beat_t exp_q [$];

  // Monitor bookkeeping.
  int cyc = 0;
  bit mon_on = 0;
  bit rand_ready = 0;
  int issue_idx, pops, outstanding;
  int first_issue_cyc, first_valid_cyc, last_pop_cyc;
  bit seen_valid, stall_prev;
  beat_t prev;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [READ_WIDTH-1:0] bank_val(input int bank, input logic [AW:0] a);
    return READ_WIDTH'(a) ^ READ_WIDTH'(a >> 5) ^ READ_WIDTH'(bank * 37);
  endfunction

  function automatic words_t fill(input int val);
    words_t w;
    for (int i = 0; i < NUM_BANKS; i++) w[i] = CW'(val);
    return w;
  endfunction

  // Port-B model: one-cycle read latency. Banks that are not enabled show garbage.
  always @(posedge clk)
    for (int i = 0; i < NUM_BANKS; i++)
      bus.doB[i] <= bus.enaB[i] ? bank_val(i, bus.addrB[i]) : READ_WIDTH'($urandom);

  initial forever @(posedge clk) cyc++;

  // Expand a half into the beats it must produce.
  task automatic build_model(input words_t w, input logic sel);
    beat_t b;
    m_max = 0;
    m_sel = sel;
    for (int i = 0; i < NUM_BANKS; i++) begin
      m_len[i] = ((int'(w[i]) > WRITE_DEPTH) ? WRITE_DEPTH : int'(w[i])) * RATIO;
      if (m_len[i] > m_max) m_max = m_len[i];
    end
    exp_q.delete();
    for (int j = 0; j < m_max; j++) begin
      b.data = '0;
      b.mask = '0;
      for (int i = 0; i < NUM_BANKS; i++)
        if (j < m_len[i]) begin
          b.mask[i] = 1'b1;
          b.data[i*READ_WIDTH +: READ_WIDTH] = bank_val(i, {sel, AW'(j)});
        end
      b.last = (j == m_max - 1);
      exp_q.push_back(b);
    end
  endtask

  // Drive out_ready, then check issues, pops, stall stability and credit every cycle.
  initial begin
    logic [AW:0]          exp_a, bad_a;
    logic [NUM_BANKS-1:0] exp_en;
    bit                   pop;
    beat_t                b;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.out_ready = rand_ready ? 1'($urandom) : 1'b1;
      #1;
      if (mon_on) begin
        if (bus.enaB != '0) begin
          exp_en = '0;
          for (int i = 0; i < NUM_BANKS; i++) exp_en[i] = (issue_idx < m_len[i]);
          check("enaB", bus.enaB, exp_en);
          exp_a = {m_sel, AW'(issue_idx)};
          bad_a = exp_a;
          for (int i = 0; i < NUM_BANKS; i++) if (bus.addrB[i] !== exp_a) bad_a = bus.addrB[i];
          check("addrB", bad_a, exp_a);
          if (issue_idx == 0) first_issue_cyc = cyc;
          issue_idx++;
        end
        if (stall_prev) begin
          check("hold_data", bus.out_data, prev.data);
          check("hold_ctl", {bus.out_valid, bus.out_mask, bus.out_last}, {1'b1, prev.mask, prev.last});
        end
        if (bus.out_valid && !seen_valid) begin
          seen_valid = 1;
          first_valid_cyc = cyc;
        end
        pop = bus.out_valid && bus.out_ready;
        if (pop) begin
          if (exp_q.size() == 0) begin
            check("extra_beat", 1'b1, 1'b0);
          end else begin
            b = exp_q.pop_front();
            check("beat_data", bus.out_data, b.data);
            check("beat_mask_last", {bus.out_mask, bus.out_last}, {b.mask, b.last});
          end
          pops++;
          last_pop_cyc = cyc;
        end
        outstanding = outstanding + int'(bus.enaB != '0) - int'(pop);
        check("outstanding_le2", outstanding > 2, 1'b0);
        stall_prev = bus.out_valid && !bus.out_ready;
        prev.data  = bus.out_data;
        prev.mask  = bus.out_mask;
        prev.last  = bus.out_last;
      end
    end
  end

  task automatic check_reset_values(input string tag);
    #1;
    check({tag, "_buf_ready"}, bus.buf_ready, 1'b1);
    check({tag, "_buf_release"}, {bus.buf_release, bus.buf_release_sel}, 2'b00);
    check({tag, "_enaB"}, bus.enaB, '0);
    check({tag, "_addrB"}, |bus.addrB, 1'b0);
    check({tag, "_out_ctl"}, {bus.out_valid, bus.out_mask, bus.out_last}, '0);
    check({tag, "_out_data"}, bus.out_data, '0);
  endtask

  // Hand a half over. h is the cycle number just after the accepting edge.
  task automatic start_half(input vec_t v, output int h);
    build_model(v.words, v.sel);
    rand_ready      = v.rand_ready;
    issue_idx       = 0;
    pops            = 0;
    outstanding     = 0;
    seen_valid      = 0;
    stall_prev      = 0;
    first_issue_cyc = -1;
    first_valid_cyc = -1;
    last_pop_cyc    = -1;
    mon_on          = 1;
    @(negedge clk);
    #2;
    check("buf_ready_idle", bus.buf_ready, 1'b1);
    bus.buf_words = v.words;
    bus.buf_sel   = v.sel;
    bus.buf_valid = 1'b1;
    h = cyc + 1;
    @(posedge clk);
    #1;
    // Scramble the handoff inputs to prove they were latched and are ignored while busy.
    for (int i = 0; i < NUM_BANKS; i++) bus.buf_words[i] = CW'($urandom);
    bus.buf_sel = ~v.sel;
  endtask

  task automatic run_case(input string name, input vec_t v);
    int   h, rel_cyc, budget;
    logic rel_sel;
    bit   ready_bad;
    start_half(v, h);
    rel_cyc   = -1;
    rel_sel   = 1'bx;
    ready_bad = 0;
    budget    = m_max * 8 + 20;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #2;
      if (bus.buf_release) begin
        rel_cyc = cyc;
        rel_sel = bus.buf_release_sel;
        bus.buf_valid = 1'b0;
        break;
      end
      if (bus.buf_ready) ready_bad = 1;
    end
    bus.buf_valid = 1'b0;
    check({name, "_release_cyc"}, rel_cyc, (m_max == 0) ? h : last_pop_cyc + 1);
    check({name, "_release_sel"}, rel_sel, v.sel);
    check({name, "_beats"}, pops, v.exp_beats);
    check({name, "_model_left"}, exp_q.size(), 0);
    check({name, "_busy_not_ready"}, ready_bad, 1'b0);
    check({name, "_weB"}, bus.weB, '0);
    if (m_max == 0) begin
      check({name, "_no_enaB"}, issue_idx, 0);
    end else begin
      check({name, "_first_enaB"}, first_issue_cyc, h);
      check({name, "_first_valid"}, first_valid_cyc, h + 2);
      if (!v.rand_ready) check({name, "_throughput"}, last_pop_cyc - first_valid_cyc, m_max - 1);
    end
    @(negedge clk);
    #2;
    check({name, "_release_pulse"}, {bus.buf_release, bus.buf_ready}, 2'b01);
    mon_on = 0;
  endtask

  initial begin
    vec_t   tbl [7];
    vec_t   r;
    words_t w;
    int     h, mx;
    bus.buf_valid = 1'b0;
    bus.buf_sel   = 1'b0;
    bus.buf_words = '0;

    repeat (3) @(negedge clk);
    check_reset_values("por");
    rst_n = 1'b1;

    tbl[0] = '{words: fill(1), sel: 1'b0, rand_ready: 1'b0, exp_beats: 16};
    w = fill(0); w[0] = CW'(2); w[1] = CW'(1);
    tbl[1] = '{words: w, sel: 1'b0, rand_ready: 1'b0, exp_beats: 32};
    tbl[2] = '{words: fill(3), sel: 1'b1, rand_ready: 1'b1, exp_beats: 48};
    tbl[3] = '{words: fill(128), sel: 1'b1, rand_ready: 1'b0, exp_beats: 2048};
    tbl[4] = '{words: fill(0), sel: 1'b1, rand_ready: 1'b0, exp_beats: 0};
    tbl[5] = '{words: fill(200), sel: 1'b0, rand_ready: 1'b0, exp_beats: 2048};
    w = fill(0); w[15] = CW'(5); w[7] = CW'(2);
    tbl[6] = '{words: w, sel: 1'b1, rand_ready: 1'b1, exp_beats: 80};

    for (int t = 0; t < 7; t++) run_case($sformatf("vec%0d", t), tbl[t]);

    // Randomized halves with random backpressure.
    for (int t = 0; t < 6; t++) begin
      mx = 0;
      for (int i = 0; i < NUM_BANKS; i++) begin
        r.words[i] = CW'($urandom_range(0, 6));
        if (int'(r.words[i]) * RATIO > mx) mx = int'(r.words[i]) * RATIO;
      end
      r.sel        = 1'($urandom);
      r.rand_ready = 1'b1;
      r.exp_beats  = mx;
      run_case($sformatf("rand%0d", t), r);
    end

    // Reset in the middle of a half, after the fifth beat has been taken.
    start_half(tbl[0], h);
    bus.buf_valid = 1'b0;
    for (int k = 0; k < 200 && pops < 5; k++) begin
      @(negedge clk);
      #2;
    end
    check("midrst_reached_beat5", pops, 5);
    mon_on = 0;
    rst_n  = 1'b0;
    check_reset_values("midrst");
    @(negedge clk);
    check("midrst_no_release", bus.buf_release, 1'b0);
    rst_n = 1'b1;
    run_case("after_rst", tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule
